// File: rtl/id_ex_register.sv
// ID/EX pipeline register: captures decode-stage controls, operands and addresses, with stall hold and bubble insertion.
// Optional bubble counter built only when ID_EX_PERF_EN is defined; otherwise bubble_cnt_o is tied to zero.
module id_ex_register #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              hazard_i,
    input  logic              valid_i,
    input  logic [2:0]        EX_i,
    input  logic [2:0]        M_i,
    input  logic [1:0]        WB_i,
    input  logic [DATA_W-1:0] RSdata_i,
    input  logic [DATA_W-1:0] RTdata_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic [4:0]        RSaddr_i,
    input  logic [4:0]        RTaddr_i,
    input  logic [4:0]        RDaddr_i,
    output logic [2:0]        EX_o,
    output logic [2:0]        M_o,
    output logic [1:0]        WB_o,
    output logic [DATA_W-1:0] RSdata_o,
    output logic [DATA_W-1:0] RTdata_o,
    output logic [DATA_W-1:0] imm_o,
    output logic [4:0]        RSaddr_o,
    output logic [4:0]        RTaddr_o,
    output logic [4:0]        RDaddr_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  bubble_cnt_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_e;

    slot_e             state_q, state_d;
    logic [2:0]        ex_q, ex_d;
    logic [2:0]        m_q, m_d;
    logic [1:0]        wb_q, wb_d;
    logic [DATA_W-1:0] rs_data_q, rs_data_d;
    logic [DATA_W-1:0] rt_data_q, rt_data_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [4:0]        rs_addr_q, rs_addr_d;
    logic [4:0]        rt_addr_q, rt_addr_d;
    logic [4:0]        rd_addr_q, rd_addr_d;

    logic load_c;
    logic bubble_c;

    assign load_c   = ~stall_i;
    assign bubble_c = flush_i | hazard_i | ~valid_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Slot state: bubble empties the slot, a real load fills it, stall holds it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (load_c && !bubble_c) state_d = FULL;
            FULL:    if (load_c && bubble_c)  state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Controls are forced to zero on a bubble regardless of the upstream mux output.
    always_comb begin
        ex_d      = ex_q;
        m_d       = m_q;
        wb_d      = wb_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        rd_addr_d = rd_addr_q;
        if (load_c) begin
            ex_d      = bubble_c ? 3'b000 : EX_i;
            m_d       = bubble_c ? 3'b000 : M_i;
            wb_d      = bubble_c ? 2'b00  : WB_i;
            rs_data_d = RSdata_i;
            rt_data_d = RTdata_i;
            imm_d     = imm_i;
            rs_addr_d = RSaddr_i;
            rt_addr_d = RTaddr_i;
            rd_addr_d = RDaddr_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_q      <= '0;
            m_q       <= '0;
            wb_q      <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rd_addr_q <= '0;
        end else begin
            ex_q      <= ex_d;
            m_q       <= m_d;
            wb_q      <= wb_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rd_addr_q <= rd_addr_d;
        end
    end

    assign EX_o     = ex_q;
    assign M_o      = m_q;
    assign WB_o     = wb_q;
    assign RSdata_o = rs_data_q;
    assign RTdata_o = rt_data_q;
    assign imm_o    = imm_q;
    assign RSaddr_o = rs_addr_q;
    assign RTaddr_o = rt_addr_q;
    assign RDaddr_o = rd_addr_q;
    assign valid_o  = (state_q == FULL);

`ifdef ID_EX_PERF_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturating count of bubble loads; frozen under stall.
    always_comb begin
        cnt_d = cnt_q;
        if (load_c && bubble_c && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bubble_cnt_o = cnt_q;
`else
    assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_register.sv
// Directed self-checking bench for id_ex_register (counter expectations follow ID_EX_PERF_EN).
module tb_id_ex_register;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned VEC_W  = 9 + 3 * DATA_W + 15 + CNT_W;

    logic              clk, rst;
    logic              stall, flush, hazard, valid;
    logic [2:0]        ex_in, m_in;
    logic [1:0]        wb_in;
    logic [DATA_W-1:0] rs_in, rt_in, imm_in;
    logic [4:0]        rsa_in, rta_in, rda_in;
    logic [2:0]        ex_out, m_out;
    logic [1:0]        wb_out;
    logic [DATA_W-1:0] rs_out, rt_out, imm_out;
    logic [4:0]        rsa_out, rta_out, rda_out;
    logic              valid_out;
    logic [CNT_W-1:0]  cnt_out;

    logic [CNT_W-1:0]  exp_cnt;
    logic [VEC_W-1:0]  obs, expv;
    int unsigned       vectors, miscompares;

    id_ex_register #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
        .hazard_i(hazard), .valid_i(valid), .EX_i(ex_in), .M_i(m_in),
        .WB_i(wb_in), .RSdata_i(rs_in), .RTdata_i(rt_in), .imm_i(imm_in),
        .RSaddr_i(rsa_in), .RTaddr_i(rta_in), .RDaddr_i(rda_in),
        .EX_o(ex_out), .M_o(m_out), .WB_o(wb_out), .RSdata_o(rs_out),
        .RTdata_o(rt_out), .imm_o(imm_out), .RSaddr_o(rsa_out),
        .RTaddr_o(rta_out), .RDaddr_o(rda_out), .valid_o(valid_out),
        .bubble_cnt_o(cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {valid_out, ex_out, m_out, wb_out, rs_out, rt_out, imm_out,
                  rsa_out, rta_out, rda_out, cnt_out};

    function automatic logic [VEC_W-1:0] exp_vec(
        input logic v, input logic [2:0] e, input logic [2:0] m, input logic [1:0] w,
        input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt, input logic [DATA_W-1:0] im,
        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d, input logic [CNT_W-1:0] c);
        return {v, e, m, w, rs, rt, im, a, b, d, c};
    endfunction

    task automatic bump();
`ifdef ID_EX_PERF_EN
        if (exp_cnt != {CNT_W{1'b1}}) exp_cnt = exp_cnt + CNT_W'(1);
`endif
    endtask

    task automatic drive(
        input logic s, input logic f, input logic h, input logic v,
        input logic [2:0] e, input logic [2:0] m, input logic [1:0] w,
        input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt, input logic [DATA_W-1:0] im,
        input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        stall = s; flush = f; hazard = h; valid = v;
        ex_in = e; m_in = m; wb_in = w;
        rs_in = rs; rt_in = rt; imm_in = im;
        rsa_in = a; rta_in = b; rda_in = d;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        expv = '0;
        vectors++;
        if (obs !== expv) begin
            $display("FAIL reset_hold got=%h want=%h", obs, expv); miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 1, 3'b110, 3'b010, 2'b11, 32'h0000_0005, 32'h1111_2222, 32'h0000_0020, 5'd1, 5'd2, 5'd3);
        @(posedge clk); #1;
        expv = exp_vec(1, 3'b110, 3'b010, 2'b11, 32'h0000_0005, 32'h1111_2222, 32'h0000_0020, 5'd1, 5'd2, 5'd3, exp_cnt);
        vectors++;
        if (obs !== expv) begin
            $display("FAIL first_load_after_reset got=%h want=%h", obs, expv); miscompares++;
        end
        #2 rst = 1'b1;
        #1;
        exp_cnt = '0;
        expv = '0;
        vectors++;
        if (obs !== expv) begin
            $display("FAIL async_reset got=%h want=%h", obs, expv); miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_normal();
        drive(0, 0, 0, 1, 3'b110, 3'b010, 2'b11, 32'h0000_0005, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 5'd4, 5'd5, 5'd6);
        @(posedge clk); #1;
        expv = exp_vec(1, 3'b110, 3'b010, 2'b11, 32'h0000_0005, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 5'd4, 5'd5, 5'd6, exp_cnt);
        vectors++;
        if (obs !== expv) begin
            $display("FAIL normal_a got=%h want=%h", obs, expv); miscompares++;
        end
        @(negedge clk);
        drive(0, 0, 0, 1, 3'b011, 3'b101, 2'b01, 32'hA5A5_5A5A, 32'h0000_0000, 32'h0000_002A, 5'd31, 5'd0, 5'd17);
        @(posedge clk); #1;
        expv = exp_vec(1, 3'b011, 3'b101, 2'b01, 32'hA5A5_5A5A, 32'h0000_0000, 32'h0000_002A, 5'd31, 5'd0, 5'd17, exp_cnt);
        vectors++;
        if (obs !== expv) begin
            $display("FAIL normal_b got=%h want=%h", obs, expv); miscompares++;
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        drive(0, 0, 1, 1, 3'b101, 3'b110, 2'b10, 32'h0000_0077, 32'h0000_0088, 32'h0000_0099, 5'd7, 5'd8, 5'd9);
        @(posedge clk); #1;
        bump();
        expv = exp_vec(0, 3'b000, 3'b000, 2'b00, 32'h0000_0077, 32'h0000_0088, 32'h0000_0099, 5'd7, 5'd8, 5'd9, exp_cnt);
        vectors++;
        if (obs !== expv) begin
            $display("FAIL load_use_bubble got=%h want=%h", obs, expv); miscompares++;
        end
    endtask

    task automatic test_flush_invalid();
        @(negedge clk);
        drive(0, 1, 0, 1, 3'b111, 3'b111, 2'b11, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 5'd10, 5'd11, 5'd12);
        @(posedge clk); #1;
        bump();
        expv = exp_vec(0, 3'b000, 3'b000, 2'b00, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 5'd10, 5'd11, 5'd12, exp_cnt);
        vectors++;
        if (obs !== expv) begin
            $display("FAIL flush_bubble got=%h want=%h", obs, expv); miscompares++;
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 3'b111, 3'b111, 2'b11, 32'h0000_0004, 32'h0000_0005, 32'h0000_0006, 5'd13, 5'd14, 5'd15);
        @(posedge clk); #1;
        bump();
        expv = exp_vec(0, 3'b000, 3'b000, 2'b00, 32'h0000_0004, 32'h0000_0005, 32'h0000_0006, 5'd13, 5'd14, 5'd15, exp_cnt);
        vectors++;
        if (obs !== expv) begin
            $display("FAIL invalid_bubble got=%h want=%h", obs, expv); miscompares++;
        end
    endtask

    task automatic test_stall();
        @(negedge clk);
        drive(0, 0, 0, 1, 3'b100, 3'b011, 2'b10, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 5'd20, 5'd21, 5'd22);
        @(posedge clk); #1;
        expv = exp_vec(1, 3'b100, 3'b011, 2'b10, 32'hCAFE_0001, 32'hCAFE_0002, 32'hCAFE_0003, 5'd20, 5'd21, 5'd22, exp_cnt);
        vectors++;
        if (obs !== expv) begin
            $display("FAIL stall_load_a got=%h want=%h", obs, expv); miscompares++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1, (i != 1), (i == 1), (i != 2), 3'(i + 1), 3'b111, 2'b01,
                  32'(i * 16), 32'hFFFF_0000, 32'h0000_1234, 5'(i), 5'(i + 3), 5'(i + 6));
            @(posedge clk); #1;
            vectors++;
            if (obs !== expv) begin
                $display("FAIL stall_hold_%0d got=%h want=%h", i, obs, expv); miscompares++;
            end
        end
        @(negedge clk);
        drive(0, 1, 0, 1, 3'b110, 3'b001, 2'b11, 32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003, 5'd23, 5'd24, 5'd25);
        @(posedge clk); #1;
        bump();
        expv = exp_vec(0, 3'b000, 3'b000, 2'b00, 32'hBEEF_0001, 32'hBEEF_0002, 32'hBEEF_0003, 5'd23, 5'd24, 5'd25, exp_cnt);
        vectors++;
        if (obs !== expv) begin
            $display("FAIL stall_release_flush got=%h want=%h", obs, expv); miscompares++;
        end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        drive(0, 0, 0, 1, 3'b010, 3'b100, 2'b10, 32'h1234_5678, 32'h8765_4321, 32'h0000_0010, 5'd26, 5'd27, 5'd28);
        @(posedge clk);
        @(negedge clk);
        stall = 1'b1;
        @(posedge clk); #1;
        expv = exp_vec(1, 3'b010, 3'b100, 2'b10, 32'h1234_5678, 32'h8765_4321, 32'h0000_0010, 5'd26, 5'd27, 5'd28, exp_cnt);
        vectors++;
        if (obs !== expv) begin
            $display("FAIL mid_stall_hold got=%h want=%h", obs, expv); miscompares++;
        end
        #2 rst = 1'b1;
        #1;
        exp_cnt = '0;
        expv = '0;
        vectors++;
        if (obs !== expv) begin
            $display("FAIL reset_mid_stall got=%h want=%h", obs, expv); miscompares++;
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            drive(0, 1, 0, 1, 3'b111, 3'b111, 2'b11, 32'(i), 32'(i + 100), 32'(i + 200), 5'(i), 5'(i + 1), 5'(i + 2));
            @(posedge clk); #1;
            bump();
            expv = exp_vec(0, 3'b000, 3'b000, 2'b00, 32'(i), 32'(i + 100), 32'(i + 200), 5'(i), 5'(i + 1), 5'(i + 2), exp_cnt);
            vectors++;
            if (obs !== expv) begin
                $display("FAIL saturate_%0d got=%h want=%h", i, obs, expv); miscompares++;
            end
        end
        @(negedge clk);
        drive(0, 0, 0, 1, 3'b001, 3'b010, 2'b01, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC, 5'd1, 5'd1, 5'd1);
        @(posedge clk); #1;
        expv = exp_vec(1, 3'b001, 3'b010, 2'b01, 32'h0000_00AA, 32'h0000_00BB, 32'h0000_00CC, 5'd1, 5'd1, 5'd1, exp_cnt);
        vectors++;
        if (obs !== expv) begin
            $display("FAIL after_saturate got=%h want=%h", obs, expv); miscompares++;
        end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        exp_cnt = '0;
        rst = 1'b1;
        drive(0, 0, 0, 0, 3'b000, 3'b000, 2'b00, '0, '0, '0, 5'd0, 5'd0, 5'd0);
        test_reset();
        test_normal();
        test_load_use();
        test_flush_invalid();
        test_stall();
        test_reset_mid_stall();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
